// File: rtl/sr_cmd_sequencer_if.sv
// Command and response handshake bundle between the command decoder (master)
// and the shift-register command sequencer (slave).
interface sr_cmd_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// Sequences serial-load / rotate / read commands onto a shared shift register
// and returns its parallel contents on a valid/ready response channel.
//
// state     | meaning
// S_IDLE    | ready for a command
// S_LOAD    | sr_load high, one cmd_data bit per cycle, MSB first
// S_ROT     | sr_shift high for cmd_count cycles, sr_dir held
// S_CAPTURE | controls idle for one cycle, then sample sr_data_out
// S_RESP    | response held until rsp_ready
module sr_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    sr_cmd_sequencer_if.slave    bus,
    output logic                 sr_load,
    output logic                 sr_shift,
    output logic                 sr_dir,
    output logic                 sr_data_in,
    input  logic [WIDTH-1:0]     sr_data_out,
    output logic                 busy
);
    localparam int CW = (CNT_W > $clog2(WIDTH) + 1) ? CNT_W : $clog2(WIDTH) + 1;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROT,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sr_load_q, sr_load_d;
    logic             sr_shift_q, sr_shift_d;
    logic             sr_dir_q, sr_dir_d;
    logic             sr_data_in_q, sr_data_in_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        sr_load_d    = sr_load_q;
        sr_shift_d   = sr_shift_q;
        sr_dir_d     = sr_dir_q;
        sr_data_in_d = sr_data_in_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        cmd_ready_d  = cmd_ready_q;
        busy_d       = busy_q;

        if (flush) begin
            // abort leaves the shift register partially updated on purpose
            state_d      = S_IDLE;
            sr_load_d    = 1'b0;
            sr_shift_d   = 1'b0;
            sr_dir_d     = 1'b0;
            sr_data_in_d = 1'b0;
            rsp_valid_d  = 1'b0;
            cmd_ready_d  = 1'b1;
            busy_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        if (bus.cmd_op == OP_READ) begin
                            state_d = S_CAPTURE;
                        end else if (bus.cmd_op == OP_LOAD) begin
                            state_d      = S_LOAD;
                            sr_load_d    = 1'b1;
                            sr_data_in_d = bus.cmd_data[WIDTH-1];
                            shreg_d      = {bus.cmd_data[WIDTH-2:0], 1'b0};
                            cnt_d        = CW'(WIDTH - 1);
                        end else if (bus.cmd_count == '0) begin
                            state_d = S_CAPTURE;
                        end else begin
                            state_d    = S_ROT;
                            sr_shift_d = 1'b1;
                            sr_dir_d   = bus.cmd_op[0];
                            cnt_d      = CW'(bus.cmd_count) - CW'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (cnt_q == '0) begin
                        state_d      = S_CAPTURE;
                        sr_load_d    = 1'b0;
                        sr_data_in_d = 1'b0;
                    end else begin
                        sr_data_in_d = shreg_q[WIDTH-1];
                        shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
                        cnt_d        = cnt_q - CW'(1);
                    end
                end
                S_ROT: begin
                    if (cnt_q == '0) begin
                        state_d    = S_CAPTURE;
                        sr_shift_d = 1'b0;
                        sr_dir_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_CAPTURE: begin
                    rsp_data_d  = sr_data_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_d = 1'b0;
                        state_d     = S_IDLE;
                        cmd_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    sr_load_d    = 1'b0;
                    sr_shift_d   = 1'b0;
                    sr_dir_d     = 1'b0;
                    sr_data_in_d = 1'b0;
                    rsp_valid_d  = 1'b0;
                    cmd_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sr_load_q    <= 1'b0;
            sr_shift_q   <= 1'b0;
            sr_dir_q     <= 1'b0;
            sr_data_in_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            sr_load_q    <= sr_load_d;
            sr_shift_q   <= sr_shift_d;
            sr_dir_q     <= sr_dir_d;
            sr_data_in_q <= sr_data_in_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign sr_load       = sr_load_q;
    assign sr_shift      = sr_shift_q;
    assign sr_dir        = sr_dir_q;
    assign sr_data_in    = sr_data_in_q;
    assign busy          = busy_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer driving a behavioural 8-bit
// serial-load / rotate shift register from the sequencer's controls.
module tb_sr_cmd_sequencer;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             sr_load, sr_shift, sr_dir, sr_data_in, busy;
    logic [WIDTH-1:0] sr_data_out;
    logic [WIDTH-1:0] sr_q = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    sr_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .sr_load     (sr_load),
        .sr_shift    (sr_shift),
        .sr_dir      (sr_dir),
        .sr_data_in  (sr_data_in),
        .sr_data_out (sr_data_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sr_load)
            sr_q <= {sr_q[WIDTH-2:0], sr_data_in};
        else if (sr_shift)
            sr_q <= sr_dir ? {sr_q[0], sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
    end
    assign sr_data_out = sr_q;

    task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                            input logic [CNT_W-1:0] cnt);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_count = cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // c = 0 is the cycle right after the accept edge
    task automatic collect(output int lat, output int n_load, output int n_shift,
                           output int n_dir1, output logic [WIDTH-1:0] din);
        lat = -1; n_load = 0; n_shift = 0; n_dir1 = 0; din = '0;
        for (int c = 0; c < 40; c++) begin
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
            if (sr_load) begin
                n_load++;
                din = {din[WIDTH-2:0], sr_data_in};
            end
            if (sr_shift) begin
                n_shift++;
                if (sr_dir) n_dir1++;
            end
            @(negedge clk);
        end
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = '0; bus.cmd_count = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({sr_load, sr_shift, sr_dir, sr_data_in} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_sr_ctrl got %b exp 0000", {sr_load, sr_shift, sr_dir, sr_data_in});
        end
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_rsp got valid=%b data=%h exp 0/00", bus.rsp_valid, bus.rsp_data);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b exp 0", busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release got ready=%b busy=%b exp 1/0", bus.cmd_ready, busy);
        end
    endtask

    task automatic test_load(input logic [WIDTH-1:0] data);
        int lat, nl, ns, nd;
        logic [WIDTH-1:0] din;
        send_cmd(OP_LOAD, data, '0);
        n_cmp++;
        if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL load_busy got busy=%b ready=%b exp 1/0", busy, bus.cmd_ready);
        end
        collect(lat, nl, ns, nd, din);
        n_cmp++;
        if (lat !== WIDTH + 1) begin
            n_fail++; $display("FAIL load_latency got %0d exp %0d", lat, WIDTH + 1);
        end
        n_cmp++;
        if (nl !== WIDTH || ns !== 0) begin
            n_fail++; $display("FAIL load_pulses got load=%0d shift=%0d exp %0d/0", nl, ns, WIDTH);
        end
        n_cmp++;
        if (din !== data) begin
            n_fail++; $display("FAIL load_bits got %h exp %h", din, data);
        end
        n_cmp++;
        if (bus.rsp_data !== data) begin
            n_fail++; $display("FAIL load_rsp got %h exp %h", bus.rsp_data, data);
        end
        take_rsp();
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_done got ready=%b valid=%b exp 1/0", bus.cmd_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_rotate(input logic [1:0] op, input int cnt, input logic [WIDTH-1:0] exp);
        int lat, nl, ns, nd;
        logic [WIDTH-1:0] din;
        send_cmd(op, 8'h00, CNT_W'(cnt));
        collect(lat, nl, ns, nd, din);
        n_cmp++;
        if (lat !== cnt + 1) begin
            n_fail++; $display("FAIL rot_latency op=%b n=%0d got %0d exp %0d", op, cnt, lat, cnt + 1);
        end
        n_cmp++;
        if (ns !== cnt || nl !== 0) begin
            n_fail++; $display("FAIL rot_pulses op=%b n=%0d got shift=%0d load=%0d exp %0d/0", op, cnt, ns, nl, cnt);
        end
        n_cmp++;
        if (nd !== ((op == OP_ROTR) ? cnt : 0)) begin
            n_fail++; $display("FAIL rot_dir op=%b n=%0d got dir1 cycles %0d", op, cnt, nd);
        end
        n_cmp++;
        if (bus.rsp_data !== exp) begin
            n_fail++; $display("FAIL rot_rsp op=%b n=%0d got %h exp %h", op, cnt, bus.rsp_data, exp);
        end
        take_rsp();
    endtask

    task automatic test_backpressure(input logic [WIDTH-1:0] exp);
        int lat, nl, ns, nd;
        logic [WIDTH-1:0] din;
        send_cmd(OP_READ, 8'h00, '0);
        collect(lat, nl, ns, nd, din);
        n_cmp++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL read_latency got %0d exp 1", lat);
        end
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = OP_LOAD; bus.cmd_data = 8'h33;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || bus.cmd_ready !== 1'b0 || sr_load !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got valid=%b data=%h ready=%b load=%b exp 1/%h/0/0",
                                   i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, sr_load, exp);
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b0 || sr_q !== exp) begin
            n_fail++; $display("FAIL bp_ignored got ready=%b reg=%h exp 0/%h", bus.cmd_ready, sr_q, exp);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got ready=%b valid=%b busy=%b exp 1/0/0",
                               bus.cmd_ready, bus.rsp_valid, busy);
        end
    endtask

    task automatic test_flush();
        int lat, nl, ns, nd, seen;
        logic [WIDTH-1:0] din;
        test_load(8'h00);
        send_cmd(OP_LOAD, 8'hAA, '0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if ({sr_load, sr_shift, sr_dir, sr_data_in} !== 4'b0000 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle got ctrl=%b busy=%b ready=%b exp 0000/0/1",
                               {sr_load, sr_shift, sr_dir, sr_data_in}, busy, bus.cmd_ready);
        end
        seen = 0;
        repeat (4) begin
            if (bus.rsp_valid) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush_no_rsp got %0d valid cycles exp 0", seen);
        end
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; flush = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (3) begin
            if (bus.rsp_valid || busy) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush_drop_cmd got %0d busy/valid cycles exp 0", seen);
        end
        send_cmd(OP_READ, 8'h00, '0);
        collect(lat, nl, ns, nd, din);
        n_cmp++;
        if (lat !== 1 || bus.rsp_data !== 8'h0A) begin
            n_fail++; $display("FAIL flush_read got lat=%0d data=%h exp 1/0a", lat, bus.rsp_data);
        end
        take_rsp();
    endtask

    task automatic test_reset_mid_rot();
        send_cmd(OP_ROTL, 8'h00, 4'd10);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sr_shift !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midrot_active got shift=%b busy=%b exp 1/1", sr_shift, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sr_shift !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrot_async got shift=%b valid=%b busy=%b exp 0/0/0",
                               sr_shift, bus.rsp_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || sr_shift !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrot_release got ready=%b busy=%b shift=%b valid=%b exp 1/0/0/0",
                               bus.cmd_ready, busy, sr_shift, bus.rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_load(8'hAA);
        test_rotate(OP_ROTL, 3, 8'h55);
        test_rotate(OP_ROTR, 3, 8'hAA);
        test_rotate(OP_ROTL, 8, 8'hAA);
        test_rotate(OP_ROTR, 0, 8'hAA);
        test_rotate(OP_ROTR, 1, 8'h55);
        test_rotate(OP_ROTL, 1, 8'hAA);
        test_backpressure(8'hAA);
        test_flush();
        test_reset_mid_rot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
